datacache_assoc: RTL and testbench
==================================

Name: datacache_assoc

Overview:
- Parametrised successor to the direct-mapped write-back data cache.
- Write-back, write-allocate, 1- or 2-way set-associative, with per-set LRU replacement.
- Supports byte-enabled writes.
- Uses a proper request/done handshake toward the CPU and a line-wide req/ack handshake toward backing memory.
- Sits between the pipeline MEM stage and the data memory model; a pipeline stall is derived from cpu_done.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, word width; must be 32 (byte enables are 4 bits).
- LINE_WORDS, 4, words per line; power of 2, at least 1.
- SETS, 4, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; legal values are 1 and 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  access request; held high, with all cpu_* inputs stable, until cpu_done.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_be  in  4  byte enables for a write; bit i covers bits [8i+7:8i].
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, or the merged word after a write; valid while cpu_done is high.
- cpu_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = line writeback, 0 = line refill.
- mem_addr  out  ADDR_W  line-aligned address (offset bits zero).
- mem_wline  out  LINE_WORDS*DATA_W  writeback line; word 0 in the LSBs.
- mem_rline  in  LINE_WORDS*DATA_W  refill line; sampled in the mem_ack cycle.
- mem_ack  in  1  one-cycle memory completion.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS*4); word select is addr[OFF-1:2].
  - Index is addr[OFF+log2(SETS)-1:OFF]; tag is the remaining high bits.
  - Defaults: word select [3:2], index [5:4], tag [31:6].
- Per-way state: tag, valid, dirty, data line. Per-set state: lru bit, meaning the way to evict next; unused when WAYS=1.
- Reset (asynchronous, rst_n low):
  - Clears all valid, dirty and lru bits; state goes to IDLE.
  - cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wline=0.
  - Reset mid-transaction aborts it immediately: mem_req drops, the dirty victim is discarded, and no cpu_done is issued.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: if cpu_req and cpu_done==0, go to LOOKUP. The cycle after cpu_done returns to IDLE, so back-to-back requests are allowed.
- LOOKUP, hit (a valid way with matching tag):
  - Read returns the word.
  - Write merges the enabled bytes, sets dirty, and returns the merged word.
  - lru is set to the other way.
  - cpu_done pulses in the next cycle; state returns to IDLE.
  - Hit latency: cpu_done two clocks after cpu_req is first sampled.
- LOOKUP, miss, victim selection: the first invalid way (way 0 preferred); otherwise the way named by lru.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wline = victim line.
  - On mem_ack, clear the victim's dirty bit and go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = the line address of cpu_addr.
  - On mem_ack: write mem_rline into the victim way, set its tag, valid=1, dirty=0; go to RESPOND.
- RESPOND: perform the access exactly as for a hit (including the write merge, dirty set and lru update), then pulse cpu_done.
- mem_req goes low in the cycle after mem_ack. Memory outputs hold stable while mem_req is high.
- A write with cpu_be=0 still allocates and completes, but leaves the data unchanged and does not set dirty.
- cpu_req dropping before cpu_done is illegal; behaviour is undefined and a bench assertion must flag it.
- WAYS=1 degenerates to direct-mapped: the victim is always way 0 and lru is ignored.

Test Plan:
- Miss then hit:
  - Stimulus: reset, then read 0x100; memory acks 3 cycles later with line {0x44,0x33,0x22,0x11} (word 3 to word 0).
  - Required: exactly one refill at mem_addr 0x100 with mem_we=0; cpu_rdata=0x11 with cpu_done.
  - Follow-up: read 0x104 → cpu_done two clocks after request, rdata 0x22, no mem_req.
- Byte write:
  - Stimulus: write 0x100 with be=4'b0010, wdata=0xAABBCCDD.
  - Required: hit; cpu_rdata=0x0000CC11; subsequent read of 0x100 returns 0x0000CC11.
- Dirty eviction:
  - Stimulus: after the byte write, read 0x200, then read 0x300.
  - Required: 0x200 fills way 1. 0x300 evicts LRU way 0, giving a writeback at mem_addr 0x100 with wline word0=0x0000CC11, then a refill at 0x300.
- Clean eviction: read 0x100 again (victim 0x200, clean) → no mem_we=1 cycle; refill only.
- Reset mid-refill: assert rst_n low while mem_req=1 → mem_req=0 in the same cycle, no cpu_done; afterwards a read of 0x300 misses.
- WAYS=1 instance: alternate reads of 0x100 and 0x140 → every access misses and refills; no writebacks.

Source files
------------

// File: rtl/datacache_assoc.sv
// Write-back, write-allocate data cache, 1- or 2-way set-associative with per-set LRU.
// CPU side uses a req/done handshake; memory side moves whole lines with req/ack.
module datacache_assoc #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 4,
   parameter int WAYS       = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cpu_req,
   input  logic                         cpu_wr,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic [3:0]                   cpu_be,
   input  logic [DATA_W-1:0]            cpu_wdata,
   output logic [DATA_W-1:0]            cpu_rdata,
   output logic                         cpu_done,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [LINE_WORDS*DATA_W-1:0] mem_wline,
   input  logic [LINE_WORDS*DATA_W-1:0] mem_rline,
   input  logic                         mem_ack
);
   localparam int OFF    = $clog2(LINE_WORDS*4);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF - IDX_W;
   localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int LINE_W = LINE_WORDS*DATA_W;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
   state_t state_q, state_d;

   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [LINE_W-1:0] data_q  [WAYS][SETS];
   logic [SETS-1:0]   valid_q [WAYS];
   logic [SETS-1:0]   dirty_q [WAYS];
   logic [SETS-1:0]   lru_q;
   logic              victim_q;

   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  idx;
   logic [WSEL_W-1:0] wsel;
   logic              hit, hit_way, vic_way, acc_way, do_access;
   logic [LINE_W-1:0] acc_line;
   logic [DATA_W-1:0] acc_word, merged;

   function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [3:0]        be);
      logic [DATA_W-1:0] m;
      m = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
      return m;
   endfunction

   assign tag  = cpu_addr[ADDR_W-1:OFF+IDX_W];
   assign idx  = cpu_addr[OFF+IDX_W-1:OFF];
   assign wsel = WSEL_W'((cpu_addr >> 2) & ADDR_W'(LINE_WORDS-1));

   // Victim prefers the lowest invalid way, else the LRU way of the set.
   always_comb begin
      hit     = 1'b0;
      hit_way = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = 1'(w);
         end
      vic_way = (WAYS > 1) ? lru_q[idx] : 1'b0;
      for (int w = WAYS-1; w >= 0; w--)
         if (!valid_q[w][idx]) vic_way = 1'(w);
   end

   assign acc_way   = (state_q == LOOKUP) ? hit_way : victim_q;
   assign acc_line  = data_q[acc_way][idx];
   assign acc_word  = acc_line[wsel*DATA_W +: DATA_W];
   assign merged    = merge_be(acc_word, cpu_wdata, cpu_be);
   assign do_access = (state_q == LOOKUP && hit) || (state_q == RESPOND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wline = '0;
      unique case (state_q)
         IDLE:
            if (cpu_req && !cpu_done) state_d = LOOKUP;
         LOOKUP:
            if (hit)                                              state_d = IDLE;
            else if (valid_q[vic_way][idx] && dirty_q[vic_way][idx]) state_d = WRITEBACK;
            else                                                  state_d = REFILL;
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_q[victim_q][idx], idx, {OFF{1'b0}}};
            mem_wline = data_q[victim_q][idx];
            if (mem_ack) state_d = REFILL;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag, idx, {OFF{1'b0}}};
            if (mem_ack) state_d = RESPOND;
         end
         RESPOND:
            state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // Control state: cleared by reset so an aborted miss leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
         lru_q     <= '0;
         victim_q  <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_done <= do_access;
         if (state_q == LOOKUP) victim_q <= vic_way;
         if (do_access) begin
            cpu_rdata <= cpu_wr ? merged : acc_word;
            if (cpu_wr && cpu_be != 4'b0000) dirty_q[acc_way][idx] <= 1'b1;
            if (WAYS > 1) lru_q[idx] <= ~acc_way;
         end
         if (state_q == WRITEBACK && mem_ack) dirty_q[victim_q][idx] <= 1'b0;
         if (state_q == REFILL && mem_ack) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == REFILL && mem_ack) begin
         data_q[victim_q][idx] <= mem_rline;
         tag_q[victim_q][idx]  <= tag;
      end else if (do_access && cpu_wr) begin
         data_q[acc_way][idx][wsel*DATA_W +: DATA_W] <= merged;
      end
   end
endmodule

// File: tb/tb_datacache_assoc.sv
// Scoreboard bench for datacache_assoc: a 2-way instance and a direct-mapped instance
// share one backing-memory model; expected CPU and memory transactions are queued up front.
module tb_datacache_assoc;
   localparam int LW = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cpu_req   [2];
   logic          cpu_wr    [2];
   logic [31:0]   cpu_addr  [2];
   logic [3:0]    cpu_be    [2];
   logic [31:0]   cpu_wdata [2];
   logic [31:0]   cpu_rdata [2];
   logic          cpu_done  [2];
   logic          mem_req   [2];
   logic          mem_we    [2];
   logic [31:0]   mem_addr  [2];
   logic [LW-1:0] mem_wline [2];
   logic [LW-1:0] mem_rline [2];
   logic          mem_ack   [2] = '{1'b0, 1'b0};
   int            mcnt      [2] = '{0, 0};

   typedef struct packed {
      logic          we;
      logic [31:0]   addr;
      logic [LW-1:0] line;
   } mem_exp_t;

   logic [31:0]   exp_cpu [$];
   mem_exp_t      exp_mem [$];
   mem_exp_t      me;
   logic [31:0]   rd_exp;
   logic [LW-1:0] bmem [logic [31:0]];
   int checks = 0;
   int passed = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      datacache_assoc #(.WAYS(g == 0 ? 2 : 1)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .cpu_req   (cpu_req[g]),
         .cpu_wr    (cpu_wr[g]),
         .cpu_addr  (cpu_addr[g]),
         .cpu_be    (cpu_be[g]),
         .cpu_wdata (cpu_wdata[g]),
         .cpu_rdata (cpu_rdata[g]),
         .cpu_done  (cpu_done[g]),
         .mem_req   (mem_req[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wline (mem_wline[g]),
         .mem_rline (mem_rline[g]),
         .mem_ack   (mem_ack[g])
      );

      a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
                                   (cpu_req[g] && !cpu_done[g]) |=> (cpu_req[g] || cpu_done[g]))
         else $error("cpu_req dropped before cpu_done on instance %0d", g);
   end

   function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endfunction

   function automatic void fail_chk(input string name, input logic [LW-1:0] act);
      checks++;
      $display("FAIL %s: got %0h, required nothing", name, act);
   endfunction

   function automatic logic [LW-1:0] dflt(input logic [31:0] a);
      return {a + 32'd12, a + 32'd8, a + 32'd4, a};
   endfunction

   function automatic void push_mem(input logic we, input logic [31:0] a, input logic [LW-1:0] line);
      mem_exp_t e;
      e.we = we;
      e.addr = a;
      e.line = line;
      exp_mem.push_back(e);
   endfunction

   // Backing memory: acks each request on the third negedge it is seen high.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            mcnt[d] = 0;
            mem_ack[d] = 1'b0;
         end else if (mem_ack[d]) begin
            mem_ack[d] = 1'b0;
            mcnt[d] = 0;
         end else if (mem_req[d]) begin
            mcnt[d]++;
            if (mcnt[d] == 3) begin
               mem_ack[d] = 1'b1;
               if (exp_mem.size() == 0) begin
                  fail_chk("unexpected mem_req", LW'({mem_we[d], mem_addr[d]}));
               end else begin
                  me = exp_mem.pop_front();
                  check("mem_we", LW'(mem_we[d]), LW'(me.we));
                  check("mem_addr", LW'(mem_addr[d]), LW'(me.addr));
                  if (me.we) check("mem_wline", mem_wline[d], me.line);
               end
               if (mem_we[d]) bmem[mem_addr[d]] = mem_wline[d];
               else mem_rline[d] = bmem.exists(mem_addr[d]) ? bmem[mem_addr[d]] : dflt(mem_addr[d]);
            end
         end else begin
            mcnt[d] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n && cpu_done[d]) begin
            if (exp_cpu.size() == 0) begin
               fail_chk("unexpected cpu_done", LW'(cpu_rdata[d]));
            end else begin
               rd_exp = exp_cpu.pop_front();
               check("cpu_rdata", LW'(cpu_rdata[d]), LW'(rd_exp));
            end
         end
      end
   end

   task automatic access(input int d, input logic wr, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
      int n;
      exp_cpu.push_back(exp_rd);
      @(negedge clk);
      cpu_wr[d]    = wr;
      cpu_addr[d]  = a;
      cpu_be[d]    = be;
      cpu_wdata[d] = wd;
      cpu_req[d]   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_done[d] && n < 100);
      if (!cpu_done[d]) fail_chk("cpu_done timeout", LW'(a));
      else if (lat > 0) check("latency", LW'(n), LW'(lat));
      cpu_req[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         cpu_req[d]   = 1'b0;
         cpu_wr[d]    = 1'b0;
         cpu_addr[d]  = '0;
         cpu_be[d]    = '0;
         cpu_wdata[d] = '0;
      end
      bmem[32'h100] = {32'h44, 32'h33, 32'h22, 32'h11};
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset cpu_done", LW'(cpu_done[d]), '0);
         check("reset cpu_rdata", LW'(cpu_rdata[d]), '0);
         check("reset mem_req", LW'(mem_req[d]), '0);
         check("reset mem_we", LW'(mem_we[d]), '0);
         check("reset mem_addr", LW'(mem_addr[d]), '0);
         check("reset mem_wline", mem_wline[d], '0);
      end
      rst_n = 1'b1;

      // 2-way instance
      push_mem(1'b0, 32'h100, '0);
      access(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h11, 6);
      access(0, 1'b0, 32'h104, 4'h0, 32'h0, 32'h22, 2);
      access(0, 1'b1, 32'h100, 4'b0010, 32'hAABBCCDD, 32'h0000CC11, 2);
      access(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000CC11, 2);
      push_mem(1'b0, 32'h200, '0);
      access(0, 1'b0, 32'h200, 4'h0, 32'h0, 32'h200, 6);
      push_mem(1'b1, 32'h100, {32'h44, 32'h33, 32'h22, 32'h0000CC11});
      push_mem(1'b0, 32'h300, '0);
      access(0, 1'b0, 32'h300, 4'h0, 32'h0, 32'h300, 10);
      push_mem(1'b0, 32'h100, '0);
      access(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000CC11, 6);
      access(0, 1'b1, 32'h304, 4'b0000, 32'hFFFFFFFF, 32'h304, 2);
      access(0, 1'b0, 32'h108, 4'h0, 32'h0, 32'h33, 2);
      push_mem(1'b0, 32'h200, '0);
      access(0, 1'b0, 32'h200, 4'h0, 32'h0, 32'h200, 6);
      push_mem(1'b0, 32'h010, '0);
      access(0, 1'b1, 32'h014, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 6);
      access(0, 1'b0, 32'h014, 4'h0, 32'h0, 32'hDEADBEEF, 2);

      // reset while a refill is outstanding
      @(negedge clk);
      cpu_wr[0]   = 1'b0;
      cpu_addr[0] = 32'h300;
      cpu_req[0]  = 1'b1;
      n = 0;
      while (!mem_req[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort mem_req before reset", LW'(mem_req[0]), LW'(1));
      rst_n = 1'b0;
      #1;
      check("abort mem_req", LW'(mem_req[0]), '0);
      check("abort mem_addr", LW'(mem_addr[0]), '0);
      check("abort cpu_done", LW'(cpu_done[0]), '0);
      cpu_req[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_mem(1'b0, 32'h300, '0);
      access(0, 1'b0, 32'h300, 4'h0, 32'h0, 32'h300, 6);
      push_mem(1'b0, 32'h010, '0);
      access(0, 1'b0, 32'h014, 4'h0, 32'h0, 32'h14, 6);

      // direct-mapped instance
      push_mem(1'b0, 32'h100, '0);
      access(1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000CC11, 6);
      push_mem(1'b0, 32'h140, '0);
      access(1, 1'b0, 32'h140, 4'h0, 32'h0, 32'h140, 6);
      push_mem(1'b0, 32'h100, '0);
      access(1, 1'b0, 32'h104, 4'h0, 32'h0, 32'h22, 6);
      push_mem(1'b0, 32'h140, '0);
      access(1, 1'b0, 32'h14C, 4'h0, 32'h0, 32'h14C, 6);
      access(1, 1'b0, 32'h148, 4'h0, 32'h0, 32'h148, 2);

      repeat (10) @(negedge clk);
      check("cpu queue drained", LW'(exp_cpu.size()), '0);
      check("mem queue drained", LW'(exp_mem.size()), '0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
